vga_pixel_fifo: RTL and testbench

Pixel buffer directly upstream of the VGA timing controller. It accepts decoded RGB pixels from the video decoder path at the decoder's own pace and delivers them one per request on the controller's `oRequest` strobe. It realigns the pixel stream to the display frame using a start-of-frame tag carried with each pixel. It outputs black and raises sticky error flags when the stream under-runs, over-runs or loses frame alignment.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_sdp_ram.sv | 24 ++
 rtl/vga_pixel_fifo.sv | 169 ++++++++++++++++
 tb/tb_vga_pixel_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel buffer: default widths, entry layout,
// read-FSM encoding and the black colour constant.
package vga_pkg;

    localparam int DW_DEFAULT    = 10;
    localparam int DEPTH_DEFAULT = 1024;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_t;

    localparam logic [DW_DEFAULT-1:0] BLACK = '0;

    // Entry layout is {SOF, R, G, B}.
    function automatic int entry_w(input int dw);
        return 3 * dw + 1;
    endfunction

    function automatic int sof_bit(input int dw);
        return 3 * dw;
    endfunction

endpackage

// File: rtl/vga_sdp_ram.sv
// Simple dual-port RAM with a registered read port, written to map onto block RAM.
module vga_sdp_ram #(
    parameter int AW    = 10,
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // NOTE: the array has no reset; resetting it would prevent block-RAM inference.
    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA timing controller; realigns the stream on the SOF
// tag and outputs black with sticky error flags on under/over-run or misalignment.
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int  DW    = DW_DEFAULT,
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iWR_EN,
    input  logic          iWR_SOF,
    input  logic [DW-1:0] iWR_R,
    input  logic [DW-1:0] iWR_G,
    input  logic [DW-1:0] iWR_B,
    input  logic          iRD_REQ,
    input  logic          iRD_VS,
    input  logic          iCLR_ERR,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic [AW:0]   oUsedw,
    output logic          oFull,
    output logic          oEmpty,
    output logic          oOverflow,
    output logic          oUnderflow,
    output logic          oSyncErr
);

    localparam int EW  = entry_w(DW);
    localparam int SOF = sof_bit(DW);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   used_nxt;
    rd_state_t     state;
    rd_state_t     state_nxt;

    logic [EW-1:0] wr_data;
    logic [EW-1:0] ram_q;
    logic [EW-1:0] byp_data;
    logic          byp_valid;
    logic [EW-1:0] head;

    logic pop;
    logic deliver;
    logic wr_ok;
    logic oflow_ev;
    logic uflow_ev;
    logic serr_ev;

    assign wr_data = {iWR_SOF, iWR_R, iWR_G, iWR_B};

    // The RAM is addressed with the post-pop pointer so its registered output
    // already holds the head entry when the next cycle's decision is made.
    vga_sdp_ram #(
        .AW    (AW),
        .WIDTH (EW)
    ) u_ram (
        .clk   (iCLK),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // A write landing on the address being read returns old RAM data, so the
    // freshly written entry is forwarded from a bypass register instead.
    assign head = byp_valid ? byp_data : ram_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pop       = 1'b0;
        deliver   = 1'b0;
        uflow_ev  = 1'b0;
        serr_ev   = 1'b0;
        state_nxt = state;

        if (iRD_VS) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (!oEmpty) begin
                        if (!head[SOF]) begin
                            pop = 1'b1;
                        end else if (iRD_REQ) begin
                            pop       = 1'b1;
                            deliver   = 1'b1;
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (iRD_REQ) begin
                        if (oEmpty) begin
                            uflow_ev = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            deliver = 1'b1;
                            if (head[SOF]) begin
                                serr_ev   = 1'b1;
                                state_nxt = ST_SYNC;
                            end
                        end
                    end
                end
                default: state_nxt = ST_SYNC;
            endcase
        end

        wr_ok    = iWR_EN && (!oFull || pop);
        oflow_ev = iWR_EN && oFull && !pop;
        rd_addr  = rd_ptr + AW'(pop);

        case ({wr_ok, pop})
            2'b10:   used_nxt = oUsedw + 1'b1;
            2'b01:   used_nxt = oUsedw - 1'b1;
            default: used_nxt = oUsedw;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            oUsedw     <= '0;
            oEmpty     <= 1'b1;
            oFull      <= 1'b0;
            state      <= ST_SYNC;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
            oSyncErr   <= 1'b0;
            byp_valid  <= 1'b0;
            byp_data   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_addr;
            oUsedw <= used_nxt;
            oEmpty <= (used_nxt == '0);
            oFull  <= (used_nxt == (AW+1)'(DEPTH));
            state  <= state_nxt;

            if (deliver) begin
                {oRed, oGreen, oBlue} <= head[SOF-1:0];
            end else begin
                {oRed, oGreen, oBlue} <= {3{DW'(BLACK)}};
            end

            // A same-cycle error event beats the clear.
            oOverflow  <= oflow_ev || (oOverflow  && !iCLR_ERR);
            oUnderflow <= uflow_ev || (oUnderflow && !iCLR_ERR);
            oSyncErr   <= serr_ev  || (oSyncErr   && !iCLR_ERR);

            byp_valid <= wr_ok && (wr_ptr == rd_addr);
            byp_data  <= wr_data;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed self-checking bench for vga_pixel_fifo with hand-computed expectations.
module tb_vga_pixel_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iWR_EN = 1'b0;
    logic          iWR_SOF = 1'b0;
    logic [DW-1:0] iWR_R = '0;
    logic [DW-1:0] iWR_G = '0;
    logic [DW-1:0] iWR_B = '0;
    logic          iRD_REQ = 1'b0;
    logic          iRD_VS = 1'b0;
    logic          iCLR_ERR = 1'b0;
    logic [DW-1:0] oRed;
    logic [DW-1:0] oGreen;
    logic [DW-1:0] oBlue;
    logic [AW:0]   oUsedw;
    logic          oFull;
    logic          oEmpty;
    logic          oOverflow;
    logic          oUnderflow;
    logic          oSyncErr;

    int total = 0;
    int bad   = 0;

    vga_pixel_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iWR_EN     (iWR_EN),
        .iWR_SOF    (iWR_SOF),
        .iWR_R      (iWR_R),
        .iWR_G      (iWR_G),
        .iWR_B      (iWR_B),
        .iRD_REQ    (iRD_REQ),
        .iRD_VS     (iRD_VS),
        .iCLR_ERR   (iCLR_ERR),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oUsedw     (oUsedw),
        .oFull      (oFull),
        .oEmpty     (oEmpty),
        .oOverflow  (oOverflow),
        .oUnderflow (oUnderflow),
        .oSyncErr   (oSyncErr)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic sof, input logic [DW-1:0] r);
        iWR_EN  = en;
        iWR_SOF = sof;
        iWR_R   = r;
        iWR_G   = r ^ 10'h3ff;
        iWR_B   = r + 10'd1;
    endtask

    task automatic push(input logic sof, input logic [DW-1:0] r);
        set_wr(1'b1, sof, r);
        tick();
    endtask

    initial begin
        // reset state
        iRST = 1'b1;
        tick();
        tick();
        check("rst_usedw", 32'(oUsedw), 0);
        check("rst_empty", 32'(oEmpty), 1);
        check("rst_full", 32'(oFull), 0);
        check("rst_rgb", 32'({oRed, oGreen, oBlue}), 0);
        check("rst_flags", 32'({oOverflow, oUnderflow, oSyncErr}), 0);
        iRST = 1'b0;

        // four pixels, first with SOF, then four requests
        push(1'b1, 10'd1);
        push(1'b0, 10'd2);
        push(1'b0, 10'd3);
        push(1'b0, 10'd4);
        set_wr(1'b0, 1'b0, '0);
        check("fill4_usedw", 32'(oUsedw), 4);
        iRD_REQ = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("seq_red", 32'(oRed), 32'(k));
            check("seq_usedw", 32'(oUsedw), 32'(4 - k));
        end
        check("seq_green", 32'(oGreen), 32'(10'd4 ^ 10'h3ff));
        check("seq_blue", 32'(oBlue), 5);
        iRD_REQ = 1'b0;
        tick();
        check("idle_black", 32'({oRed, oGreen, oBlue}), 0);
        check("seq_flags", 32'({oOverflow, oUnderflow, oSyncErr}), 0);
        check("seq_empty", 32'(oEmpty), 1);

        // underflow in RUN, clear loses to same-cycle event, then clears
        iRD_REQ = 1'b1;
        tick();
        check("uflow_black", 32'(oRed), 0);
        check("uflow_flag", 32'(oUnderflow), 1);
        iCLR_ERR = 1'b1;
        tick();
        check("uflow_clr_vs_event", 32'(oUnderflow), 1);
        iRD_REQ = 1'b0;
        tick();
        check("uflow_cleared", 32'(oUnderflow), 0);
        iCLR_ERR = 1'b0;

        // back to SYNC, three non-SOF pixels get discarded at one per cycle
        iRD_VS = 1'b1;
        tick();
        iRD_VS = 1'b0;
        push(1'b0, 10'd5);
        check("disc_usedw_a", 32'(oUsedw), 1);
        push(1'b0, 10'd6);
        push(1'b0, 10'd7);
        push(1'b1, 10'd9);
        set_wr(1'b0, 1'b0, '0);
        check("disc_usedw_d", 32'(oUsedw), 1);
        tick();
        check("disc_hold", 32'(oUsedw), 1);
        check("disc_black", 32'(oRed), 0);
        iRD_REQ = 1'b1;
        tick();
        check("disc_red9", 32'(oRed), 9);
        check("disc_usedw0", 32'(oUsedw), 0);
        check("disc_syncerr", 32'(oSyncErr), 0);
        iRD_REQ = 1'b0;

        // SOF popped in RUN: pixel out, sync error, then back in SYNC
        push(1'b0, 10'd20);
        push(1'b1, 10'd21);
        push(1'b0, 10'd22);
        set_wr(1'b0, 1'b0, '0);
        iRD_REQ = 1'b1;
        tick();
        check("run_red20", 32'(oRed), 20);
        check("run_serr0", 32'(oSyncErr), 0);
        tick();
        check("run_red21", 32'(oRed), 21);
        check("run_serr1", 32'(oSyncErr), 1);
        tick();
        check("resync_black", 32'(oRed), 0);
        check("resync_discard", 32'(oUsedw), 0);
        iRD_REQ  = 1'b0;
        iCLR_ERR = 1'b1;
        tick();
        iCLR_ERR = 1'b0;
        check("serr_cleared", 32'(oSyncErr), 0);

        // VS beats a same-cycle request, both from SYNC and from RUN
        push(1'b1, 10'd30);
        set_wr(1'b0, 1'b0, '0);
        iRD_REQ = 1'b1;
        iRD_VS  = 1'b1;
        tick();
        check("vs_sync_black", 32'(oRed), 0);
        check("vs_sync_nopop", 32'(oUsedw), 1);
        iRD_VS = 1'b0;
        tick();
        check("vs_sync_red30", 32'(oRed), 30);
        iRD_REQ = 1'b0;
        push(1'b0, 10'd31);
        set_wr(1'b0, 1'b0, '0);
        iRD_REQ = 1'b1;
        iRD_VS  = 1'b1;
        tick();
        check("vs_run_black", 32'(oRed), 0);
        check("vs_run_nopop", 32'(oUsedw), 1);
        iRD_REQ = 1'b0;
        iRD_VS  = 1'b0;
        tick();
        check("vs_run_to_sync", 32'(oUsedw), 0);
        check("vs_no_uflow", 32'(oUnderflow), 0);

        // fill to DEPTH behind a held SOF head, overflow, then write+pop when full
        for (int i = 0; i < DEPTH; i++) begin
            push(i == 0, DW'((i + 100) % DEPTH));
        end
        check("full_usedw", 32'(oUsedw), DEPTH);
        check("full_flag", 32'(oFull), 1);
        check("full_no_oflow", 32'(oOverflow), 0);
        push(1'b0, 10'd999);
        check("oflow_flag", 32'(oOverflow), 1);
        check("oflow_usedw", 32'(oUsedw), DEPTH);
        iRD_REQ = 1'b1;
        push(1'b0, 10'd555);
        set_wr(1'b0, 1'b0, '0);
        check("full_wrpop_red", 32'(oRed), 100);
        check("full_wrpop_usedw", 32'(oUsedw), DEPTH);
        check("full_wrpop_full", 32'(oFull), 1);
        for (int k = 1; k <= 524; k++) begin
            tick();
            if (k == 1) check("drain_red101", 32'(oRed), 101);
        end
        check("drain_red624", 32'(oRed), 624);
        check("drain_usedw500", 32'(oUsedw), 500);
        check("drain_oflow_sticky", 32'(oOverflow), 1);
        iRD_REQ = 1'b0;

        // reset mid-stream discards everything and returns to SYNC
        iRST = 1'b1;
        tick();
        check("mid_rst_usedw", 32'(oUsedw), 0);
        check("mid_rst_empty", 32'(oEmpty), 1);
        check("mid_rst_rgb", 32'({oRed, oGreen, oBlue}), 0);
        check("mid_rst_flags", 32'({oOverflow, oUnderflow, oSyncErr}), 0);
        iRST = 1'b0;
        push(1'b0, 10'd7);
        set_wr(1'b0, 1'b0, '0);
        check("post_rst_wr", 32'(oUsedw), 1);
        tick();
        check("post_rst_discard", 32'(oUsedw), 0);
        push(1'b1, 10'd8);
        set_wr(1'b0, 1'b0, '0);
        iRD_REQ = 1'b1;
        tick();
        check("post_rst_red8", 32'(oRed), 8);
        iRD_REQ = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
